// File: rtl/cpuy_pkg.sv
// cpuy_pkg: shared cpuy constants: interrupt controller register map, state type and vectors.
package cpuy_pkg;
    localparam logic [1:0] INTC_CTRL    = 2'd0;
    localparam logic [1:0] INTC_ENABLE  = 2'd1;
    localparam logic [1:0] INTC_EDGE    = 2'd2;
    localparam logic [1:0] INTC_PENDING = 2'd3;

    typedef enum logic {
        INTC_IDLE = 1'b0,
        INTC_REQ  = 1'b1
    } intc_state_e;

    // The core's reset vector sits just below the first interrupt vector.
    localparam logic [11:0] CPUY_RESET_VEC  = 12'h000;
    localparam logic [11:0] CPUY_VEC_BASE   = 12'h010;
    localparam logic [11:0] CPUY_VEC_STRIDE = 12'h010;
endpackage

// File: rtl/cpuy_intc_prio.sv
// cpuy_intc_prio: lowest-index-wins priority encoder with valid flag.
module cpuy_intc_prio #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   idx
);
    assign valid = |req;

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = 3'(i);
    end
endmodule

// File: rtl/cpuy_intc.sv
// cpuy_intc: vectored interrupt controller with per-source mask, edge/level mode,
// fixed priority and optional nesting, handing the CPU a vector over req/ack.
module cpuy_intc
    import cpuy_pkg::*;
#(
    parameter int                NUM_SRC    = 4,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(CPUY_VEC_BASE),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(CPUY_VEC_STRIDE),
    parameter int                NESTING    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata,
    output logic               irq_req,
    output logic [2:0]         irq_id,
    output logic [ADDR_W-1:0]  irq_vector,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic [NUM_SRC-1:0] in_service
);
    intc_state_e        state_q, state_d;
    logic               gie_q, gie_d, req_q, req_d;
    logic [2:0]         id_q, id_d;
    logic [ADDR_W-1:0]  vec_q, vec_d;
    logic [NUM_SRC-1:0] en_q, en_d, edge_q, edge_d, pend_q, pend_d, isr_q, isr_d, prev_q;
    logic [NUM_SRC-1:0] wdata, blocked, eligible, id_mask, ack_mask, eoi_mask, w1c;
    logic               win_v, top_v, unused_wdata;
    logic [2:0]         win_idx, top_idx;

    assign wdata        = cfg_wdata[NUM_SRC-1:0];
    assign unused_wdata = ^cfg_wdata;
    assign eligible     = pend_q & en_q & ~isr_q;

    cpuy_intc_prio #(.N(NUM_SRC)) u_win (
        .req   (eligible & ~blocked),
        .valid (win_v),
        .idx   (win_idx)
    );

    cpuy_intc_prio #(.N(NUM_SRC)) u_top (
        .req   (isr_q),
        .valid (top_v),
        .idx   (top_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            blocked[i] = top_v && (NESTING == 0 || 3'(i) >= top_idx);
    end

    always_comb begin
        id_mask  = NUM_SRC'(1) << id_q;
        ack_mask = (state_q == INTC_REQ && irq_ack) ? id_mask : '0;
        eoi_mask = (eoi && top_v) ? NUM_SRC'(1) << top_idx : '0;
        w1c      = (cfg_we && cfg_addr == INTC_PENDING) ? wdata : '0;
        gie_d    = (cfg_we && cfg_addr == INTC_CTRL) ? cfg_wdata[0] : gie_q;
        en_d     = (cfg_we && cfg_addr == INTC_ENABLE) ? wdata : en_q;
        edge_d   = (cfg_we && cfg_addr == INTC_EDGE) ? wdata : edge_q;
        // A new edge beats a same-cycle clear; level bits just track the line.
        pend_d   = (edge_q & ((pend_q & ~(w1c | ack_mask)) | (src_irq & ~prev_q)))
                 | (~edge_q & src_irq);
        isr_d    = (isr_q & ~eoi_mask) | ack_mask;
        state_d  = state_q;
        req_d    = req_q;
        id_d     = id_q;
        vec_d    = vec_q;
        if (state_q == INTC_IDLE) begin
            if (gie_q && win_v) begin
                state_d = INTC_REQ;
                req_d   = 1'b1;
                id_d    = win_idx;
                vec_d   = VEC_BASE + ADDR_W'(win_idx) * VEC_STRIDE;
            end
        end else if (irq_ack || !(|(pend_q & en_q & id_mask)) || !gie_q) begin
            state_d = INTC_IDLE;
            req_d   = 1'b0;
        end
    end

    always_comb begin
        cfg_rdata = cfg_addr == INTC_CTRL   ? {7'd0, gie_q} :
                    cfg_addr == INTC_ENABLE ? 8'(en_q) :
                    cfg_addr == INTC_EDGE   ? 8'(edge_q) : 8'(pend_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INTC_IDLE;
            gie_q   <= 1'b0;
            req_q   <= 1'b0;
            id_q    <= '0;
            vec_q   <= VEC_BASE;
            en_q    <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            gie_q   <= gie_d;
            req_q   <= req_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            en_q    <= en_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            prev_q  <= src_irq;
        end
    end

    assign irq_req    = req_q;
    assign irq_id     = id_q;
    assign irq_vector = vec_q;
    assign in_service = isr_q;
endmodule

// File: tb/tb_cpuy_intc.sv
// tb_cpuy_intc: directed table plus hand sequences for cpuy_intc, with a NESTING=0 twin.
module tb_cpuy_intc;
    logic        clk, rst, cfg_we, irq_ack, eoi;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata, rd, rd0;
    logic [3:0]  src, isr, isr0;
    logic        req, req0;
    logic [2:0]  id, id0;
    logic [11:0] vec, vec0;
    int          n_cmp = 0;
    int          n_bad = 0;

    cpuy_intc dut (
        .clk(clk), .rst(rst), .src_irq(src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(rd), .irq_req(req), .irq_id(id),
        .irq_vector(vec), .irq_ack(irq_ack), .eoi(eoi), .in_service(isr)
    );

    cpuy_intc #(.NESTING(0)) dut0 (
        .clk(clk), .rst(rst), .src_irq(src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(rd0), .irq_req(req0), .irq_id(id0),
        .irq_vector(vec0), .irq_ack(irq_ack), .eoi(eoi), .in_service(isr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wd;
        logic [3:0]  src;
        logic        ack;
        logic        eoi;
        logic        req;
        logic [2:0]  id;
        logic [11:0] vec;
        logic [3:0]  isr;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl[11];

    task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic [3:0] s, input logic k, input logic e);
        cfg_we = w; cfg_addr = a; cfg_wdata = d; src = s; irq_ack = k; eoi = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{0, 2'd1, 8'h00, 4'b0000, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h00};
        tbl[1]  = '{0, 2'd2, 8'h00, 4'b0000, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h00};
        tbl[2]  = '{0, 2'd3, 8'h00, 4'b0000, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h00};
        tbl[3]  = '{1, 2'd0, 8'hFF, 4'b0000, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h01};
        tbl[4]  = '{1, 2'd1, 8'hF2, 4'b0000, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h02};
        tbl[5]  = '{1, 2'd2, 8'h02, 4'b0000, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h02};
        tbl[6]  = '{0, 2'd3, 8'h00, 4'b0010, 0, 0, 0, 3'd0, 12'h010, 4'b0000, 8'h02};
        tbl[7]  = '{0, 2'd3, 8'h00, 4'b0000, 0, 0, 1, 3'd1, 12'h020, 4'b0000, 8'h02};
        tbl[8]  = '{0, 2'd3, 8'h00, 4'b0000, 1, 0, 0, 3'd1, 12'h020, 4'b0010, 8'h00};
        tbl[9]  = '{0, 2'd3, 8'h00, 4'b0000, 1, 0, 0, 3'd1, 12'h020, 4'b0010, 8'h00};
        tbl[10] = '{0, 2'd3, 8'h00, 4'b0000, 0, 1, 0, 3'd1, 12'h020, 4'b0000, 8'h00};

        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst req", req, 0);
        chk("rst id", id, 0);
        chk("rst vec", vec, 12'h010);
        chk("rst isr", isr, 0);
        chk("rst ctrl", rd, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].src, tbl[i].ack, tbl[i].eoi);
            chk($sformatf("row%0d req", i), req, tbl[i].req);
            chk($sformatf("row%0d id", i), id, tbl[i].id);
            chk($sformatf("row%0d vec", i), vec, tbl[i].vec);
            chk($sformatf("row%0d isr", i), isr, tbl[i].isr);
            chk($sformatf("row%0d rdata", i), rd, tbl[i].rd);
        end

        // Nesting: source 2 in service, then edges on 3 and 0.
        step(1, 1, 8'h0F, 4'b0000, 0, 0);
        step(1, 2, 8'h0F, 4'b0000, 0, 0);
        step(0, 3, 0, 4'b0100, 0, 0);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("src2 req", req, 1);
        chk("src2 vec", vec, 12'h030);
        chk("src2 req nonest", req0, 1);
        step(0, 3, 0, 4'b0000, 1, 0);
        chk("src2 isr", isr, 4'b0100);
        chk("src2 isr nonest", isr0, 4'b0100);
        step(0, 3, 0, 4'b1000, 0, 0);
        step(0, 3, 0, 4'b0000, 0, 0);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("src3 blocked", req, 0);
        chk("src3 blocked nonest", req0, 0);
        step(0, 3, 0, 4'b0001, 0, 0);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("preempt req", req, 1);
        chk("preempt id", id, 0);
        chk("preempt vec", vec, 12'h010);
        chk("nonest no preempt", req0, 0);
        step(0, 3, 0, 4'b0000, 1, 1);
        chk("eoi+ack isr", isr, 4'b0001);
        chk("eoi+ack req", req, 0);
        chk("eoi nonest isr", isr0, 4'b0000);
        step(1, 3, 8'h08, 4'b0000, 0, 0);
        chk("w1c pending", rd, 8'h00);
        step(0, 3, 0, 4'b0000, 0, 1);
        chk("eoi isr", isr, 4'b0000);

        // Level source withdrawn before ack.
        step(1, 2, 8'h00, 4'b0000, 0, 0);
        step(0, 3, 0, 4'b0010, 0, 0);
        step(0, 3, 0, 4'b0010, 0, 0);
        chk("level req", req, 1);
        chk("level id", id, 1);
        chk("level vec", vec, 12'h020);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("level held", req, 1);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("withdraw req", req, 0);
        chk("withdraw isr", isr, 4'b0000);

        // Edge arriving with a W1C on the same bit keeps it pending.
        step(1, 1, 8'h00, 4'b0000, 0, 0);
        step(1, 2, 8'h01, 4'b0000, 0, 0);
        step(0, 3, 0, 4'b0001, 0, 0);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("edge pending", rd, 8'h01);
        step(1, 3, 8'h01, 4'b0001, 0, 0);
        chk("set wins", rd, 8'h01);
        step(1, 3, 8'h01, 4'b0001, 0, 0);
        chk("w1c clears", rd, 8'h00);

        // Reset while a request is outstanding.
        step(1, 1, 8'h01, 4'b0000, 0, 0);
        step(0, 3, 0, 4'b0001, 0, 0);
        step(0, 3, 0, 4'b0000, 0, 0);
        chk("pre-rst req", req, 1);
        chk("pre-rst vec", vec, 12'h010);
        rst = 1'b1;
        step(0, 3, 0, 4'b0000, 0, 0);
        rst = 1'b0;
        chk("mid rst req", req, 0);
        chk("mid rst vec", vec, 12'h010);
        chk("mid rst isr", isr, 0);
        chk("mid rst pending", rd, 0);
        chk("mid rst req nonest", req0, 0);
        step(0, 0, 0, 4'b0000, 0, 0);
        chk("mid rst ctrl", rd, 0);
        step(0, 1, 0, 4'b0000, 0, 0);
        chk("mid rst enable", rd, 0);
        step(0, 1, 0, 4'b0001, 0, 0);
        step(0, 1, 0, 4'b0000, 0, 0);
        step(0, 1, 0, 4'b0000, 0, 0);
        chk("post rst quiet", req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
